// File: rtl/fc_ctrl_if.sv
// fc_ctrl_if
//   Handshake, address and strobe bundle between the fully connected layer
//   sequencer (fc_ctrl) and its datapath / stream neighbours.
//   Parameters:
//     XW : x-memory address width
//     WW : weight-ROM address width
//   Signals:
//     input_valid  / input_ready  : upstream input-vector word stream
//     output_valid / output_ready : downstream result stream
//     x_wr_en, x_addr             : x-memory write strobe and address
//     w_addr                      : weight-ROM read address
//     mac_clr, mac_en             : MAC strobes aligned to memory read data
//   Modports:
//     master : controller side (drives readies, valids, addresses, strobes)
//     slave  : datapath / stream side (drives input_valid and output_ready)
interface fc_ctrl_if #(
  parameter int XW = 1,
  parameter int WW = 4
);
  logic          input_valid;
  logic          input_ready;
  logic          output_valid;
  logic          output_ready;
  logic          x_wr_en;
  logic [XW-1:0] x_addr;
  logic [WW-1:0] w_addr;
  logic          mac_clr;
  logic          mac_en;

  modport master (
    input  input_valid, output_ready,
    output input_ready, output_valid, x_wr_en, x_addr, w_addr, mac_clr, mac_en
  );

  modport slave (
    output input_valid, output_ready,
    input  input_ready, output_valid, x_wr_en, x_addr, w_addr, mac_clr, mac_en
  );
endinterface

// File: rtl/fc_ctrl.sv
// fc_ctrl
//   Sequencing controller for an M x N fully connected layer datapath with a
//   single MAC. Loads an N-word input vector into x-memory, then for each of
//   the M weight rows issues N reads (x-memory and weight ROM), waits one
//   cycle for the last product to accumulate, and presents the row result on
//   the output stream. Vectors never overlap.
//   Parameters:
//     M  : output vector length (weight rows)
//     N  : input vector length (weight columns)
//     XW : x-memory address width
//     WW : weight-ROM address width
//   Ports:
//     clk       : clock, rising edge
//     reset     : asynchronous, active-high
//     bus       : fc_ctrl_if.master (streams, addresses, MAC strobes)
//     stall_cnt : [15:0] saturating count of OUT cycles with output_ready=0
//                 (present only when FC_CTRL_STATS_EN is defined)
//   Build option:
//     FC_CTRL_STATS_EN : adds the stall_cnt output and its counter.
module fc_ctrl #(
  parameter int M  = 5,
  parameter int N  = 2,
  parameter int XW = (N > 1) ? $clog2(N) : 1,
  parameter int WW = (M * N > 1) ? $clog2(M * N) : 1
) (
  input  logic        clk,
  input  logic        reset,
  fc_ctrl_if.master   bus
`ifdef FC_CTRL_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam logic [XW-1:0] C_LAST = XW'(N - 1);
  localparam logic [RW-1:0] R_LAST = RW'(M - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t        r_state;
  logic [XW-1:0] r_c;
  logic [RW-1:0] r_r;
  logic [WW-1:0] r_w_addr;
  logic          r_mac_en;
  logic          r_mac_clr;

  logic w_in_load;
  logic w_in_hs;
  logic w_c_last;
  logic w_r_last;

  // input_ready is gated by reset so it reads 0 while reset is held even
  // though the state register already sits in LOAD.
  assign w_in_load = (r_state == ST_LOAD) && !reset;
  assign w_in_hs   = w_in_load && bus.input_valid;
  assign w_c_last  = (r_c == C_LAST);
  assign w_r_last  = (r_r == R_LAST);

  assign bus.input_ready  = w_in_load;
  assign bus.x_wr_en      = w_in_hs;
  assign bus.output_valid = (r_state == ST_OUT);
  // The counter c is the write address while loading and the read address
  // while computing; elsewhere the address is parked at 0.
  assign bus.x_addr       = (r_state == ST_LOAD || r_state == ST_COMPUTE) ? r_c : '0;
  assign bus.w_addr       = r_w_addr;
  assign bus.mac_en       = r_mac_en;
  assign bus.mac_clr      = r_mac_clr;

  // r_w_addr tracks r*N+c incrementally: it steps with c inside a row and
  // steps once more on the OUT handshake, so it holds its value through
  // WAIT/OUT/LOAD and restarts at 0 when a new vector begins computing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_LOAD;
      r_c       <= '0;
      r_r       <= '0;
      r_w_addr  <= '0;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
    end else begin
      // Strobes are the issue flags delayed one cycle to meet read data.
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          if (w_in_hs) begin
            if (w_c_last) begin
              r_c      <= '0;
              r_r      <= '0;
              r_w_addr <= '0;
              r_state  <= ST_COMPUTE;
            end else begin
              r_c <= r_c + XW'(1);
            end
          end
        end
        ST_COMPUTE: begin
          r_mac_en  <= 1'b1;
          r_mac_clr <= (r_c == '0);
          if (w_c_last) begin
            r_c     <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_c      <= r_c + XW'(1);
            r_w_addr <= r_w_addr + WW'(1);
          end
        end
        ST_WAIT: begin
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (bus.output_ready) begin
            if (w_r_last) begin
              r_r     <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_r      <= r_r + RW'(1);
              r_w_addr <= r_w_addr + WW'(1);
              r_state  <= ST_COMPUTE;
            end
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

`ifdef FC_CTRL_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (r_state == ST_OUT && !bus.output_ready && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
